eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
Shares the single GMII transmit framer between NUM_REQ packet sources, for example the XVC reply path and the ARP/ICMP responder. Grants one whole frame at a time using round-robin arbitration and forwards bytes over a valid/ready/last stream. Pads runt frames up to MIN_FRAME_LEN and truncates overlong ones. Enforces an idle gap between frames handed to the framer, which adds preamble, SFD and CRC.

Parameters:
NUM_REQ, 2, number of requesting sources (2..8)
MIN_FRAME_LEN, 60, minimum payload bytes per frame (before CRC); shorter frames are zero-padded
MAX_FRAME_LEN, 1514, maximum bytes forwarded per frame; excess is truncated
GAP_CYCLES, 12, idle mac_clk cycles inserted after each frame

Ports:
mac_clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-source byte valid
req_data  in  8*NUM_REQ  per-source byte; source i on bits [8i+7:8i]
req_last  in  NUM_REQ  per-source last byte of frame
req_ready  out  NUM_REQ  per-source byte accepted
out_data  out  8  byte to framer
out_valid  out  1  byte valid to framer
out_last  out  1  last byte of frame to framer
out_ready  in  1  framer accepts byte
grant  out  NUM_REQ  one-hot current owner; 0 when no owner
busy  out  1  high in any state other than IDLE
trunc_pulse  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset is synchronous, active-high, on mac_clk. Reset is honoured in any state, including mid-frame.
  - On reset: state=IDLE, grant=0, busy=0, out_valid=0, out_last=0, req_ready=0, trunc_pulse=0, byte count=0, rr pointer=NUM_REQ-1 (source 0 has first priority).
- States are IDLE, PASS, PAD, DRAIN, GAP.
- A transfer occurs on a cycle where out_valid && out_ready.
- Byte count is 11 bits. It is cleared on grant and increments on each transfer (PASS and PAD).
- IDLE:
  - If any req_valid is set, register grant to the first set index searched from rr_ptr+1 upward, modulo NUM_REQ.
  - Set rr_ptr to the granted index, then go to PASS.
  - Arbitration costs one cycle. No byte is accepted in IDLE.
- PASS (g = granted index):
  - out_data=req_data[g] and out_valid=req_valid[g], combinationally (zero latency).
  - req_ready[g]=out_ready; all other req_ready bits are 0.
  - On a transfer with req_last[g]:
    - If count+1 >= MIN_FRAME_LEN: out_last=1 on that byte, then go to GAP.
    - Otherwise: out_last=0 on that byte, then go to PAD.
  - On a transfer where count+1 == MAX_FRAME_LEN and req_last[g]=0:
    - Force out_last=1 on that byte and pulse trunc_pulse; go to DRAIN.
    - If req_last[g]=1 on that same byte, it is a normal end, not truncation.
- PAD:
  - out_valid=1, out_data=8'h00, req_ready=0.
  - out_last=1 on the transfer where count+1 == MIN_FRAME_LEN, then go to GAP.
- DRAIN:
  - req_ready[g]=1 and out_valid=0; source bytes are discarded until a req_last[g] byte is accepted, then go to GAP.
- GAP:
  - out_valid=0 and all req_ready=0 for GAP_CYCLES cycles (counter from 0 to GAP_CYCLES-1).
  - Then grant=0 and go to IDLE.
- Other sources stay stalled (req_ready=0) for the whole frame. A request arriving in GAP is arbitrated in the next IDLE cycle.
- out_ready low holds state and count. out_data and out_last must stay stable while out_valid && !out_ready (the source obeys the same rule).
- A req_valid drop inside a frame inserts bubbles only; the grant is kept until req_last.

Optional Feature:
- Macro: ARB_PRIORITY_EN.
- When defined: source 0 has strict priority. IDLE grants source 0 whenever req_valid[0] is set; otherwise the remaining sources are served round-robin. The rr pointer covers indices 1..NUM_REQ-1 only.
- When undefined: pure round-robin over all sources, as described above.
- Frames in progress are never preempted in either mode.

Test Plan:
- After reset, source 0 sends a 64-byte frame, out_ready=1 → one IDLE cycle, grant=01, 64 bytes on out_data in order, out_last on byte 64, then 12 cycles of out_valid=0, busy=0.
- Sources 0 and 1 both hold a pending frame continuously → grants alternate 01,10,01,10. Under ARB_PRIORITY_EN, grants stay 01 while req_valid[0]=1.
- Source 1 sends a 20-byte frame → 20 source bytes followed by 40 bytes of 0x00; out_last on output byte 60; req_ready[1]=0 during PAD.
- Source 0 sends a 1600-byte frame → 1514 bytes forwarded, out_last on byte 1514, trunc_pulse=1 for one cycle, 86 bytes consumed with out_valid=0, then GAP.
- out_ready toggles 1,0,1,0 during PASS → no byte lost or duplicated, out_data stable while stalled, total of 64 transfers.
- reset asserted at byte 30 of a frame → next cycle grant=0, out_valid=0, busy=0, req_ready=0; the next frame arbitrates normally from source 0.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// Round-robin frame arbiter in front of the GMII transmit framer: pads runts, truncates giants, spaces frames.
// Define ARB_PRIORITY_EN to give source 0 strict priority over the round-robin sources.
module eth_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int MIN_FRAME_LEN = 60,
  parameter int MAX_FRAME_LEN = 1514,
  parameter int GAP_CYCLES    = 12
) (
  input  logic                 mac_clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 trunc_pulse
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [10:0] MIN_L = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PASS  = 3'd1;
  localparam logic [2:0] S_PAD   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [10:0]        cnt_q, cnt_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic [10:0]        cnt_inc;
  logic               xfer;
  logic               found;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      idx;

  assign cnt_inc = cnt_q + 11'd1;
  assign xfer    = out_valid && out_ready;
  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
`ifdef ARB_PRIORITY_EN
    if (req_valid[0]) begin
      found = 1'b1;
    end else begin
      // rr_q only ever holds 1..NUM_REQ-1 in this mode
      for (int i = 1; i < NUM_REQ; i++) begin
        idx = IW'(((int'(rr_q) - 1 + i) % (NUM_REQ - 1)) + 1);
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end
`else
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(rr_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
`endif
  end

  // out_last depends only on count and req_last, so it stays stable while stalled
  always_comb begin
    out_data    = 8'h00;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    req_ready   = '0;
    trunc_pulse = 1'b0;
    case (state_q)
      S_PASS: begin
        out_data          = req_data[{gidx_q, 3'b000} +: 8];
        out_valid         = req_valid[gidx_q];
        req_ready[gidx_q] = out_ready;
        if (req_last[gidx_q]) begin
          out_last = (cnt_inc >= MIN_L);
        end else if (cnt_inc == MAX_L) begin
          out_last    = 1'b1;
          trunc_pulse = out_ready && req_valid[gidx_q];
        end
      end
      S_PAD: begin
        out_valid = 1'b1;
        out_last  = (cnt_inc == MIN_L);
      end
      S_DRAIN: req_ready[gidx_q] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gap_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          gidx_d       = sel;
          cnt_d        = '0;
          state_d      = S_PASS;
`ifdef ARB_PRIORITY_EN
          if (sel != '0) rr_d = sel;
`else
          rr_d = sel;
`endif
        end
      end
      S_PASS: begin
        if (xfer) begin
          cnt_d = cnt_inc;
          if (req_last[gidx_q]) state_d = (cnt_inc >= MIN_L) ? S_GAP : S_PAD;
          else if (cnt_inc == MAX_L) state_d = S_DRAIN;
        end
      end
      S_PAD: begin
        if (xfer) begin
          cnt_d = cnt_inc;
          if (cnt_inc == MIN_L) state_d = S_GAP;
        end
      end
      S_DRAIN: begin
        if (req_valid[gidx_q] && req_last[gidx_q]) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge mac_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: frames are queued per source, expected output bytes and grants
// are queued at issue time and a negedge monitor pops and compares on every framer transfer.
module tb_eth_tx_arbiter;
  localparam int NREQ = 2;
  localparam int MIN  = 60;
  localparam int MAX  = 1514;
  localparam int GAP  = 12;

  logic            mac_clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            trunc_pulse;

  eth_tx_arbiter #(.NUM_REQ(NREQ), .MIN_FRAME_LEN(MIN), .MAX_FRAME_LEN(MAX), .GAP_CYCLES(GAP)) dut (
    .mac_clk(mac_clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .grant(grant), .busy(busy),
    .trunc_pulse(trunc_pulse)
  );

  always #5 mac_clk = ~mac_clk;

  logic [8:0] srcq0[$];
  logic [8:0] srcq1[$];
  logic [8:0] expq[$];
  logic [NREQ-1:0] expg[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int acc0     = 0;
  int acc1     = 0;
  int trunc_cnt = 0;
  int last_gap = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int src, input int len, input logic [7:0] seed);
    int n;
    for (int k = 0; k < len; k++) begin
      if (src == 0) srcq0.push_back({(k == len - 1), seed + 8'(k)});
      else          srcq1.push_back({(k == len - 1), seed + 8'(k)});
    end
    n = (len > MAX) ? MAX : len;
    for (int k = 0; k < n; k++) expq.push_back({((k == n - 1) && (n >= MIN)), seed + 8'(k)});
    for (int k = n; k < MIN; k++) expq.push_back({(k == MIN - 1), 8'h00});
    expg.push_back((src == 0) ? 2'b01 : 2'b10);
  endtask

  // source model: accept sampled at negedge, queue advanced just after the edge
  initial begin
    logic [NREQ-1:0] acc;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge mac_clk);
      acc = req_valid & req_ready;
      @(posedge mac_clk);
      #1;
      if (acc[0] && srcq0.size() > 0) begin void'(srcq0.pop_front()); acc0++; end
      if (acc[1] && srcq1.size() > 0) begin void'(srcq1.pop_front()); acc1++; end
      req_valid[0] = (srcq0.size() > 0);
      {req_last[0], req_data[7:0]} = (srcq0.size() > 0) ? srcq0[0] : 9'h000;
      req_valid[1] = (srcq1.size() > 0);
      {req_last[1], req_data[15:8]} = (srcq1.size() > 0) ? srcq1[0] : 9'h000;
    end
  end

  logic [NREQ-1:0] prev_grant = '0;
  logic            hold_pend = 1'b0;
  logic [8:0]      hold_v = '0;
  logic            gap_trk = 1'b0;
  int              gap_run = 0;

  always @(negedge mac_clk) begin
    if (reset) begin
      prev_grant = '0; hold_pend = 1'b0; gap_trk = 1'b0;
    end else begin
      if (hold_pend && out_valid) chk("stall_stable", {23'd0, out_last, out_data}, {23'd0, hold_v});
      hold_pend = out_valid && !out_ready;
      hold_v    = {out_last, out_data};
      if (out_valid && out_ready) begin
        n_xfer++;
        if (expq.size() == 0) chk("unexpected_byte", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
        else chk("out_byte", {23'd0, out_last, out_data}, {23'd0, expq.pop_front()});
        if (out_last) begin gap_trk = 1'b1; gap_run = 0; end
      end else if (gap_trk) begin
        if (busy && !out_valid) gap_run++;
        else begin gap_trk = 1'b0; last_gap = gap_run; end
      end
      if (trunc_pulse) begin
        trunc_cnt++;
        chk("trunc_on_last", {29'd0, out_valid, out_ready, out_last}, 32'd7);
      end
      if (prev_grant == '0 && grant != '0) begin
        if (expg.size() == 0) chk("unexpected_grant", {30'd0, grant}, 32'hFFFF_FFFF);
        else chk("grant", {30'd0, grant}, {30'd0, expg.pop_front()});
      end
      prev_grant = grant;
    end
  end

  task automatic wait_done(input int budget, input bit toggle);
    int cyc = 0;
    while (!(expq.size() == 0 && srcq0.size() == 0 && srcq1.size() == 0 && !busy) && cyc < budget) begin
      @(posedge mac_clk);
      #1;
      if (toggle) out_ready = ~out_ready;
      cyc++;
    end
    out_ready = 1'b1;
    if (cyc >= budget) chk("timeout", cyc, 32'd0);
    repeat (2) @(posedge mac_clk);
    #1;
  endtask

  task automatic check_idle();
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_trunc", {31'd0, trunc_pulse}, 32'd0);
  endtask

  initial begin
    int a0, a1, t0, x0, cyc;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge mac_clk);
    #1;
    check_idle();
    reset = 1'b0;

    // 64-byte frame from source 0
    a0 = acc0; t0 = trunc_cnt;
    push_frame(0, 64, 8'h01);
    wait_done(500, 1'b0);
    chk("t1_gap", last_gap, GAP);
    chk("t1_accepted", acc0 - a0, 64);
    chk("t1_no_trunc", trunc_cnt - t0, 0);

    // 20-byte runt from source 1, padded to 60
    a1 = acc1; last_gap = -1;
    push_frame(1, 20, 8'h40);
    wait_done(500, 1'b0);
    chk("t2_gap", last_gap, GAP);
    chk("t2_accepted", acc1 - a1, 20);

    // both sources continuously pending: grants alternate 01,10,01,10
    push_frame(0, 64, 8'h10);
    push_frame(1, 61, 8'h80);
    push_frame(0, 64, 8'h30);
    push_frame(1, 61, 8'hA0);
    wait_done(2000, 1'b0);

    // 1600-byte giant: 1514 forwarded, rest drained
    a0 = acc0; t0 = trunc_cnt; x0 = n_xfer;
    push_frame(0, 1600, 8'h00);
    wait_done(5000, 1'b0);
    chk("t4_trunc_pulses", trunc_cnt - t0, 1);
    chk("t4_forwarded", n_xfer - x0, MAX);
    chk("t4_consumed", acc0 - a0, 1600);

    // out_ready toggling during PASS
    x0 = n_xfer;
    push_frame(1, 64, 8'h55);
    wait_done(1000, 1'b1);
    chk("t5_transfers", n_xfer - x0, 64);

    // reset in the middle of a frame
    x0 = n_xfer; cyc = 0;
    push_frame(0, 64, 8'h20);
    while (n_xfer < x0 + 30 && cyc < 500) begin
      @(posedge mac_clk);
      #1;
      cyc++;
    end
    if (cyc >= 500) chk("t6_timeout", cyc, 32'd0);
    out_ready = 1'b0;
    reset = 1'b1;
    srcq0.delete(); srcq1.delete(); expq.delete(); expg.delete();
    @(posedge mac_clk);
    #1;
    check_idle();
    @(posedge mac_clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    push_frame(0, 64, 8'h70);
    push_frame(1, 64, 8'h90);
    wait_done(1000, 1'b0);

    chk("exp_bytes_left", expq.size(), 0);
    chk("exp_grants_left", expg.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
